// File: rtl/score_seg_driver.sv
// Two-digit multiplexed 7-segment score display with frame-aligned snapshots.
// Optional goal flash compiled in with SEG_BLINK_EN.
module score_seg_driver #(
  parameter int REFRESH_DIV   = 100000,
  parameter int BLINK_HALF    = 25000000,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dis_score,
  input  logic [3:0] score0,
  input  logic [3:0] score1,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       blinking
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_slot;
  logic             r_en_prev;
  logic [3:0]       r_snap0;
  logic [3:0]       r_snap1;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  logic       w_cnt_last;
  logic       w_load;
  logic [3:0] w_snap0_next;
  logic [3:0] w_snap1_next;
  logic       w_blank;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'b1000000;
      4'd1:    f_decode = 7'b1111001;
      4'd2:    f_decode = 7'b0100100;
      4'd3:    f_decode = 7'b0110000;
      4'd4:    f_decode = 7'b0011001;
      4'd5:    f_decode = 7'b0010010;
      4'd6:    f_decode = 7'b0000010;
      4'd7:    f_decode = 7'b1111000;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0010000;
      default: f_decode = 7'b0111111;
    endcase
  endfunction

  // Snapshots reload only on frame boundaries or on re-enable, so a frame is never torn.
  assign w_cnt_last   = (r_cnt == CNT_LAST);
  assign w_load       = dis_score && (!r_en_prev || (r_slot == 2'd3 && w_cnt_last));
  assign w_snap0_next = w_load ? score0 : r_snap0;
  assign w_snap1_next = w_load ? score1 : r_snap1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_slot    <= 2'd0;
      r_en_prev <= 1'b0;
      r_snap0   <= 4'd0;
      r_snap1   <= 4'd0;
    end else if (!dis_score) begin
      r_cnt     <= '0;
      r_slot    <= 2'd0;
      r_en_prev <= 1'b0;
    end else begin
      r_en_prev <= 1'b1;
      if (w_cnt_last) begin
        r_cnt  <= '0;
        r_slot <= r_slot + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_snap0 <= w_snap0_next;
      r_snap1 <= w_snap1_next;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int BH_W = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BLINK_HALF - 1);
  localparam logic [BH_W-1:0] BH_LAST = BH_W'(BLINK_TOGGLES - 1);

  logic            r_blink_act;
  logic [BT_W-1:0] r_btimer;
  logic [BH_W-1:0] r_bhalf;
  logic            w_bact_next;
  logic [BT_W-1:0] w_btimer_next;
  logic [BH_W-1:0] w_bhalf_next;
  logic            w_differ;

  assign w_differ = (score0 != r_snap0) || (score1 != r_snap1);

  always_comb begin
    w_bact_next   = r_blink_act;
    w_btimer_next = r_btimer;
    w_bhalf_next  = r_bhalf;
    if (!dis_score) begin
      w_bact_next   = 1'b0;
      w_btimer_next = '0;
      w_bhalf_next  = '0;
    end else if (w_load && w_differ) begin
      w_bact_next   = 1'b1;
      w_btimer_next = '0;
      w_bhalf_next  = '0;
    end else if (r_blink_act) begin
      if (r_btimer == BT_LAST) begin
        w_btimer_next = '0;
        if (r_bhalf == BH_LAST) w_bact_next = 1'b0;
        else                    w_bhalf_next = r_bhalf + 1'b1;
      end else begin
        w_btimer_next = r_btimer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_act <= 1'b0;
      r_btimer    <= '0;
      r_bhalf     <= '0;
    end else begin
      r_blink_act <= w_bact_next;
      r_btimer    <= w_btimer_next;
      r_bhalf     <= w_bhalf_next;
    end
  end

  // Even half-periods are the dark phase, so every flash opens with the display off.
  assign w_blank  = w_bact_next && !w_bhalf_next[0];
  assign blinking = r_blink_act;
`else
  assign w_blank  = 1'b0;
  assign blinking = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else if (!dis_score || w_blank) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      case (r_slot)
        2'd0: begin
          r_an  <= 4'b1110;
          r_seg <= f_decode(w_snap0_next);
        end
        2'd1: begin
          if (w_snap1_next != 4'd0) begin
            r_an  <= 4'b1101;
            r_seg <= f_decode(w_snap1_next);
          end
        end
        default: ;
      endcase
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_score_seg_driver.sv
// Scoreboard bench for score_seg_driver: a time-indexed reference model queues the
// expected outputs of every clock edge, and a negedge monitor compares them.
module tb_score_seg_driver;
  localparam int RD = 4;
  localparam int BH = 8;
  localparam int BT = 2;
  localparam int FRAME = 4 * RD;
  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  logic       clk;
  logic       rst;
  logic       dis_score;
  logic [3:0] score0;
  logic [3:0] score1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       blinking;

  score_seg_driver #(.REFRESH_DIV(RD), .BLINK_HALF(BH), .BLINK_TOGGLES(BT)) dut (
    .clk(clk), .rst(rst), .dis_score(dis_score), .score0(score0), .score1(score1),
    .an(an), .seg(seg), .dp(dp), .blinking(blinking));

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    bit         seg_care;
    logic       blink;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model state: edges since enable, running edge time, snapshot, flash start time.
  int       m_k = 0;
  int       m_t = 0;
  bit       m_en_prev = 0;
  logic [3:0] m_s0 = 4'd0;
  logic [3:0] m_s1 = 4'd0;
  bit       m_f_on = 0;
  int       m_f_start = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic d, input logic [3:0] a0, input logic [3:0] a1);
    exp_t e;
    int   pos, slot, el;
    bit   act, off;
    e.an = 4'b1111; e.seg = 7'b1111111; e.seg_care = 1; e.blink = 1'b0;
    if (!d) begin
      m_k = 0; m_en_prev = 0; m_f_on = 0;
    end else begin
      pos  = m_k % FRAME;
      slot = pos / RD;
      if (!m_en_prev || pos == FRAME - 1) begin
`ifdef SEG_BLINK_EN
        if (a0 != m_s0 || a1 != m_s1) begin
          m_f_on = 1; m_f_start = m_t;
        end
`endif
        m_s0 = a0; m_s1 = a1;
      end
      el  = m_t - m_f_start;
      act = m_f_on && (el < BH * BT);
      if (!act) m_f_on = 0;
      off = act && ((el / BH) % 2 == 0);
      e.blink = act;
      if (!off) begin
        if (slot == 0) begin
          e.an = 4'b1110; e.seg = DEC[m_s0];
        end else if (slot == 1 && m_s1 != 4'd0) begin
          e.an = 4'b1101; e.seg = DEC[m_s1];
        end
      end
      e.seg_care = (e.an != 4'b1111);
      m_k++;
      m_en_prev = 1;
    end
    m_t++;
    q.push_back(e);
  endtask

  task automatic cyc(input logic d, input logic [3:0] a0, input logic [3:0] a1);
    dis_score = d; score0 = a0; score1 = a1;
    @(posedge clk);
    model_edge(d, a0, a1);
    #1;
  endtask

  // Called one time unit after an edge; reset lands between negedge and next posedge.
  task automatic async_reset(input int hold);
    #6;
    rst = 1'b1;
    #1;
    n_vec++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || blinking !== 1'b0 || dp !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset t=%0t an=%b seg=%b blinking=%b dp=%b, need an=1111 seg=1111111 blinking=0 dp=1",
               $time, an, seg, blinking, dp);
    end
    q.delete();
    m_k = 0; m_en_prev = 0; m_s0 = 4'd0; m_s1 = 4'd0; m_f_on = 0;
    repeat (hold) @(posedge clk);
    #2 rst = 1'b0;
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (an !== e.an || blinking !== e.blink || dp !== 1'b1 ||
            (e.seg_care && seg !== e.seg)) begin
          n_err++;
          $display("FAIL scan t=%0t an=%b need %b, seg=%b need %b (checked=%0d), blinking=%b need %b, dp=%b need 1",
                   $time, an, e.an, seg, e.seg, e.seg_care, blinking, e.blink, dp);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog t=%0t bench did not finish in time", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] r0, r1;
    rst = 1'b0; dis_score = 1'b0; score0 = 4'd0; score1 = 4'd0;
    #1;
    async_reset(2);

    repeat (40) cyc(1, 4'd7, 4'd4);
    repeat (6)  cyc(1, 4'd7, 4'd4);
    async_reset(1);
    repeat (20) cyc(1, 4'd0, 4'd0);
    repeat (20) cyc(1, 4'd3, 4'd0);
    repeat (20) cyc(1, 4'd12, 4'd0);
    repeat (9)  cyc(1, 4'd2, 4'd5);
    repeat (24) cyc(1, 4'd3, 4'd5);

    repeat (2)  cyc(0, 4'd5, 4'd0);
    repeat (40) cyc(1, 4'd5, 4'd0);
    repeat (10) cyc(1, 4'd6, 4'd0);
    repeat (10) cyc(1, 4'd6, 4'd0);
    repeat (40) cyc(1, 4'd7, 4'd0);

    repeat (20) cyc(1, 4'd8, 4'd0);
    repeat (2)  cyc(0, 4'd8, 4'd0);
    repeat (20) cyc(1, 4'd1, 4'd9);
    async_reset(1);
    repeat (30) cyc(1, 4'd1, 4'd9);

    r0 = 4'd0; r1 = 4'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 23) == 0) begin
        r0 = 4'($urandom_range(0, 15));
        r1 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 299) == 0) async_reset($urandom_range(1, 3));
      cyc(($urandom_range(0, 63) != 0), r0, r1);
    end

    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain %0d expected outputs left unchecked, need 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/score_seg_driver.md
SCORE_SEG_DRIVER -- requirements
Module: score_seg_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (min 2).
REQ-002 Parameter BLINK_HALF, default 25000000, clk cycles per blink half-period (min 1).
REQ-003 Parameter BLINK_TOGGLES, default 6, blink half-periods per goal flash (min 1).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 dis_score  input  1  display enable; 0 blanks display.
REQ-007 score0  input  4  BCD units digit from score counter.
REQ-008 score1  input  4  BCD tens digit from score counter.
REQ-009 an  output  4  digit anodes, active low, an[0] rightmost.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active low.
REQ-011 dp  output  1  decimal point, active low; held 1.
REQ-012 blinking  output  1  high while goal flash in progress.

Function
REQ-013 Refresh counter cnt SHALL count 0..REFRESH_DIV-1 while dis_score=1; at terminal count it wraps and slot advances 0->1->2->3->0.
REQ-014 dis_score=0 SHALL hold cnt=0, slot=0, an=4'b1111, seg=7'b1111111, blinking=0.
REQ-015 Snapshot registers snap0/snap1 SHALL load score0/score1 only when slot=3 and cnt at terminal count (frame boundary), and on the first cycle dis_score is 1 after being 0; no torn frames.
REQ-016 an and seg SHALL be registered: value for slot N appears exactly one clk after slot becomes N.
REQ-017 Slot 0 drives an=4'b1110 with snap0; slot 1 drives an=4'b1101 with snap1; slots 2,3 drive an=4'b1111 (constant duty cycle).
REQ-018 Leading-zero blanking: slot 1 with snap1=0 SHALL drive an=4'b1111.
REQ-019 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 Values 10..15 (invalid BCD) SHALL decode to dash 0111111.
REQ-021 Display is a pure consumer: score0/score1 are never modified or echoed upstream.

Reset
REQ-022 rst=1 SHALL immediately, independent of clk, force cnt=0, slot=0, snap0=snap1=0, blink state idle, an=4'b1111, seg=7'b1111111, dp=1, blinking=0.
REQ-023 Reset mid-scan or mid-blink SHALL abort both; after release first slot-0 output appears one clk after first enabled edge.

Configuration
REQ-024 Macro SEG_BLINK_EN compiled in: a snapshot load whose value differs from previous snapshot (dis_score=1) starts flash: blinking=1, phase timer counts BLINK_HALF cycles per half-period, phase starts "off" (all anodes 1111), toggles, ends after BLINK_TOGGLES half-periods.
REQ-025 With SEG_BLINK_EN, a new differing snapshot during flash SHALL restart flash from first half-period; dis_score=0 SHALL abort flash; scan counter keeps running during flash.
REQ-026 SEG_BLINK_EN absent: no blink timer logic, blinking tied 0, an never blanked except by REQ-014/017/018.

Verification (REFRESH_DIV=4, BLINK_HALF=8, BLINK_TOGGLES=2)
REQ-027 rst pulse mid-frame -> an=1111, seg=1111111 asynchronously; after release and dis_score=1, an=1110, seg=1000000 one clk after first edge.
REQ-028 score1=4, score0=7 held -> repeating an 1110/seg 1111000, an 1101/seg 0011001, then 1111,1111, each 4 clks.
REQ-029 score1=0, score0=3 -> slot 1 an=1111; score0=12 -> slot 0 seg=0111111.
REQ-030 score0 changes 2->3 mid-frame -> displayed digit unchanged until next frame boundary, then seg=0110000.
REQ-031 SEG_BLINK_EN on, score 05->06 -> blinking=1 for 16 clks, an=1111 for first 8, normal scan next 8; second change at clk 10 restarts 16-clk window.
REQ-032 dis_score dropped during flash -> next clk an=1111, blinking=0, cnt=0; SEG_BLINK_EN off -> blinking stays 0 on all changes.
